inv_affine_transform: RTL and testbench
=======================================

Name: inv_affine_transform

Overview:
- Inverse of the CLM affine stage: recovers x from y = T·x ⊕ t over GF(2), i.e. x = T⁻¹·(y ⊕ t).
- On configuration, inverts T by sequential Gauss-Jordan elimination, one column per cycle, then serves a valid/ready stream.
- Sits on the decode/unmasking side, mirroring the forward affine stage; flags singular T.

Parameters:
- N, 8, state width in bits; state_t is N bits, nn_matrix_t is N rows of N bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  T/t configuration offered
- cfg_ready  out  1  block accepts configuration (IDLE, READY or SINGULAR state)
- T  in  nn_matrix_t  forward matrix; row i gives output bit i = parity(T[i] & x)
- t  in  state_t  forward offset vector
- busy  out  1  inversion in progress
- singular  out  1  last configured T not invertible
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted
- in  in  state_t  transformed word y
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out  out  state_t  recovered word x
- check_err  out  1  self-check failure (INV_SELFCHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset values: state IDLE; cfg_ready=1, busy=0, singular=0, in_ready=0, out_valid=0, out=0, check_err=0; A, Tinv and t_reg cleared.
- FSM states: IDLE, ELIM, (CHECK), READY, SINGULAR.
- Configuration:
  - Handshake cfg_valid&cfg_ready in IDLE, READY or SINGULAR: latch A←T, Tinv←I, t_reg←t, k←0; go to ELIM.
  - Drop the output register (out_valid←0).
- ELIM, column k per cycle:
  - Pivot = lowest row r≥k with A[r][k]=1. None: go to SINGULAR.
  - Otherwise swap rows r,k in A and Tinv. Then for every row j≠k with A[j][k]=1, XOR row k into row j in both A and Tinv.
  - k==N-1 with pivot found: go to READY (or CHECK). Latency is exactly N cycles from config accept to READY.
- SINGULAR:
  - singular=1, in_ready=0; held until the next configuration.
- READY:
  - in_ready = !out_valid | out_ready (one-entry output register).
  - On accept: out ← Tinv·(in ⊕ t_reg), out_valid←1, at the next edge. Latency is 1 cycle.
  - out/out_valid hold stable while out_valid & !out_ready.
  - Simultaneous output accept and input accept: the new word replaces the old, no bubble.
- cfg_valid is ignored during ELIM/CHECK (cfg_ready=0).
- busy=1 exactly in ELIM/CHECK.
- rst_n low on any edge, including mid-ELIM: all state returns to reset values and the inversion is abandoned.

Optional Feature:
- Macro INV_SELFCHECK_EN.
- Defined: after ELIM, one CHECK cycle computes T_saved·Tinv, with T_saved an extra latched copy of T.
  - Result ≠ I: check_err=1 (sticky until next config or reset), go to SINGULAR.
  - Otherwise go to READY. Latency becomes N+1.
- Undefined: no T copy, no CHECK state, check_err tied 0.

Decomposition:
- Package types:
  - state_t, nn_matrix_t (N-sized).
  - New enum inv_state_e {IDLE, ELIM, CHECK, READY, SINGULAR}.
  - Function gf2_identity() returning nn_matrix_t.
- Existing matrix_mul instanced for the data path (Tinv·(in⊕t)) and for the CHECK product, column by column.
- One new sub-module gf2_elim_step: combinational single-column pivot/swap/eliminate on [A|Tinv]. Inputs A, Tinv, k; outputs A', Tinv', found.

Test Plan (N=8):
- T=I, t=0x00, in=0x3C → out=0x3C; busy for exactly 8 cycles after cfg accept; singular=0.
- T=I, t=0xA5, in=0xFF → out=0x5A.
- T=bit-reversal permutation, t=0x00, in=0x01 → out=0x80; in=0x0F → out=0xF0.
- T with row1=row0 → singular=1 by cfg accept +8 cycles; in_ready stays 0. Reconfigure with T=I → singular clears, in_ready=1.
- Random invertible T/t, 256 words through the forward affine stage then this block, with random out_ready stalls → every output equals the original word, in order, none lost or duplicated.
- rst_n=0 asserted at ELIM cycle 4 → next cycle cfg_ready=1, busy=0, out_valid=0. Under INV_SELFCHECK_EN, a forced Tinv corruption → check_err=1.

Source files
------------

// File: rtl/inv_affine_transform_pkg.sv
// Shared types for the inverse affine stage.
// N-bit state word, NxN GF(2) matrix, FSM encoding, identity helper.
package inv_affine_transform_pkg;

    localparam int N  = 8;
    localparam int KW = $clog2(N);

    typedef logic [N-1:0]        state_t;
    typedef logic [N-1:0][N-1:0] nn_matrix_t;

    typedef enum logic [2:0] {
        IDLE,
        ELIM,
        CHECK,
        READY,
        SINGULAR
    } inv_state_e;

    function automatic nn_matrix_t gf2_identity();
        nn_matrix_t m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i][i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/inv_affine_transform_gf2_elim_step.sv
// One Gauss-Jordan column step on the augmented pair [A|Tinv].
// Ports: a_i/inv_i current rows, k_i column; a_o/inv_o next rows, found_o pivot seen.
module gf2_elim_step
    import inv_affine_transform_pkg::*;
(
    input  logic [N-1:0][N-1:0] a_i,
    input  logic [N-1:0][N-1:0] inv_i,
    input  logic [KW-1:0]       k_i,
    output logic [N-1:0][N-1:0] a_o,
    output logic [N-1:0][N-1:0] inv_o,
    output logic                found_o
);

    logic [KW-1:0]       piv;
    logic [N-1:0][N-1:0] sa;
    logic [N-1:0][N-1:0] si;

    always_comb begin
        found_o = 1'b0;
        piv     = '0;
        // Descending scan so the lowest qualifying row wins.
        for (int r = N - 1; r >= 0; r--) begin
            if (r >= int'(k_i) && a_i[r][k_i]) begin
                found_o = 1'b1;
                piv     = KW'(r);
            end
        end

        sa = a_i;
        si = inv_i;
        if (found_o) begin
            sa[k_i] = a_i[piv];
            sa[piv] = a_i[k_i];
            si[k_i] = inv_i[piv];
            si[piv] = inv_i[k_i];
        end

        a_o   = sa;
        inv_o = si;
        for (int j = 0; j < N; j++) begin
            if (j != int'(k_i) && sa[j][k_i]) begin
                a_o[j]   = sa[j] ^ sa[k_i];
                inv_o[j] = si[j] ^ si[k_i];
            end
        end
    end

endmodule

// File: rtl/inv_affine_transform_matrix_mul.sv
// GF(2) matrix-vector product y = M*x.
// Ports: m_i matrix (row i -> bit i), x_i vector, y_o product.
module matrix_mul
    import inv_affine_transform_pkg::*;
(
    input  logic [N-1:0][N-1:0] m_i,
    input  logic [N-1:0]        x_i,
    output logic [N-1:0]        y_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < N; i++) begin
            y_o[i] = ^(m_i[i] & x_i);
        end
    end

endmodule

// File: rtl/inv_affine_transform.sv
// Inverse affine stage: x = Tinv*(y ^ t), Tinv found by per-column elimination.
// Ports: cfg_valid/cfg_ready + T,t config; in/out valid-ready stream;
// busy, singular, check_err status. Optional macro: INV_SELFCHECK_EN.
module inv_affine_transform
    import inv_affine_transform_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [N-1:0][N-1:0] T,
    input  logic [N-1:0]        t,
    output logic                busy,
    output logic                singular,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out,
    output logic                check_err
);

    inv_state_e          state_q, state_d;
    logic [N-1:0][N-1:0] a_q, a_d;
    logic [N-1:0][N-1:0] tinv_q, tinv_d;
    logic [N-1:0]        t_q, t_d;
    logic [N-1:0]        out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [KW-1:0]       k_q, k_d;

    logic [N-1:0][N-1:0] a_nx, tinv_nx;
    logic                found;
    logic [N-1:0]        dp_x, dp_y;
    logic                cfg_fire, in_fire;

    gf2_elim_step u_elim (
        .a_i     (a_q),
        .inv_i   (tinv_q),
        .k_i     (k_q),
        .a_o     (a_nx),
        .inv_o   (tinv_nx),
        .found_o (found)
    );

    assign dp_x = in ^ t_q;

    matrix_mul u_dp (
        .m_i (tinv_q),
        .x_i (dp_x),
        .y_o (dp_y)
    );

`ifdef INV_SELFCHECK_EN
    logic [N-1:0][N-1:0] tsave_q, tsave_d;
    logic [N-1:0][N-1:0] tinv_cols, prod_cols;
    logic                chk_err_q, chk_err_d;
    logic                check_ok;

    always_comb begin
        tinv_cols = '0;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                tinv_cols[c][i] = tinv_q[i][c];
            end
        end
    end

    // prod_cols[c] is column c of T*Tinv; the transpose of I is I.
    for (genvar c = 0; c < N; c++) begin : g_chk
        matrix_mul u_chk (
            .m_i (tsave_q),
            .x_i (tinv_cols[c]),
            .y_o (prod_cols[c])
        );
    end

    assign check_ok  = (prod_cols == gf2_identity());
    assign check_err = chk_err_q;
`else
    assign check_err = 1'b0;
`endif

    assign cfg_ready = (state_q == IDLE) || (state_q == READY) ||
                       (state_q == SINGULAR);
    assign busy      = (state_q == ELIM) || (state_q == CHECK);
    assign singular  = (state_q == SINGULAR);
    assign in_ready  = (state_q == READY) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        tinv_d      = tinv_q;
        t_d         = t_q;
        k_d         = k_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef INV_SELFCHECK_EN
        tsave_d     = tsave_q;
        chk_err_d   = chk_err_q;
`endif

        unique case (state_q)
            ELIM: begin
                a_d    = a_nx;
                tinv_d = tinv_nx;
                if (!found) begin
                    state_d = SINGULAR;
                end else if (k_q == KW'(N - 1)) begin
`ifdef INV_SELFCHECK_EN
                    state_d = CHECK;
`else
                    state_d = READY;
`endif
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            CHECK: begin
`ifdef INV_SELFCHECK_EN
                if (check_ok) begin
                    state_d = READY;
                end else begin
                    state_d   = SINGULAR;
                    chk_err_d = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: ;
        endcase

        if (in_fire) begin
            out_d       = dp_y;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // New configuration overrides everything, including a word
        // accepted in the same READY cycle.
        if (cfg_fire) begin
            state_d     = ELIM;
            a_d         = T;
            tinv_d      = gf2_identity();
            t_d         = t;
            k_d         = '0;
            out_valid_d = 1'b0;
`ifdef INV_SELFCHECK_EN
            tsave_d     = T;
            chk_err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            tinv_q      <= '0;
            t_q         <= '0;
            k_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef INV_SELFCHECK_EN
            tsave_q     <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            tinv_q      <= tinv_d;
            t_q         <= t_d;
            k_q         <= k_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef INV_SELFCHECK_EN
            tsave_q     <= tsave_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_inv_affine_transform.sv
// Directed and streamed checks for inv_affine_transform (N=8).
// Honors INV_SELFCHECK_EN for latency and the corruption check.
module tb_inv_affine_transform;
    import inv_affine_transform_pkg::*;

`ifdef INV_SELFCHECK_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [N-1:0][N-1:0] T_s;
    logic [N-1:0]        t_s;
    logic                busy;
    logic                singular;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        din;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        dout;
    logic                check_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inv_affine_transform dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .T         (T_s),
        .t         (t_s),
        .busy      (busy),
        .singular  (singular),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .check_err (check_err)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0][N-1:0] ident();
        logic [N-1:0][N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i][i] = 1'b1;
        return m;
    endfunction

    // Forward affine stage: y[i] = parity(T[i] & x) ^ t[i].
    function automatic logic [N-1:0] fwd(input logic [N-1:0][N-1:0] m,
                                         input logic [N-1:0] v,
                                         input logic [N-1:0] x);
        logic [N-1:0] y;
        for (int i = 0; i < N; i++) y[i] = (^(m[i] & x)) ^ v[i];
        return y;
    endfunction

    task automatic do_cfg(input logic [N-1:0][N-1:0] m,
                          input logic [N-1:0] v, input bit wait_busy,
                          output int nbusy);
        int n;
        @(negedge clk);
        T_s = m;
        t_s = v;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) expect_eq("cfg_ready_timeout", 0, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        nbusy = 0;
        if (wait_busy) begin
            while (busy && nbusy < 40) begin
                nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic send(input logic [N-1:0] x, input string tag,
                        input logic [N-1:0] exp);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        din       = x;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) expect_eq({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_eq(tag, 32'(dout), 32'(exp));
        expect_eq({tag, "_valid"}, 32'(out_valid), 1);
    endtask

    logic [N-1:0][N-1:0] tm;
    logic [N-1:0]        tv;
    logic [N-1:0]        xs [256];
    int                  nb, tx, rx, cyc;

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        T_s       = '0;
        t_s       = '0;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("rst_cfg_ready", 32'(cfg_ready), 1);
        expect_eq("rst_busy", 32'(busy), 0);
        expect_eq("rst_singular", 32'(singular), 0);
        expect_eq("rst_in_ready", 32'(in_ready), 0);
        expect_eq("rst_out_valid", 32'(out_valid), 0);
        expect_eq("rst_out", 32'(dout), 0);
        expect_eq("rst_check_err", 32'(check_err), 0);
        rst_n = 1'b1;

        // Identity, zero offset
        do_cfg(ident(), 8'h00, 1'b1, nb);
        expect_eq("id_busy_cycles", nb, LAT);
        expect_eq("id_singular", 32'(singular), 0);
        expect_eq("id_in_ready", 32'(in_ready), 1);
        send(8'h3C, "id_3c", 8'h3C);

        // Output register stall and back-to-back replace
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = 8'h11;
        @(negedge clk);
        din = 8'h22;
        repeat (3) @(negedge clk);
        expect_eq("stall_out", 32'(dout), 32'h11);
        expect_eq("stall_valid", 32'(out_valid), 1);
        expect_eq("stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_eq("replace_out", 32'(dout), 32'h22);
        expect_eq("replace_valid", 32'(out_valid), 1);
        @(negedge clk);
        expect_eq("drain_valid", 32'(out_valid), 0);

        // Identity with offset
        do_cfg(ident(), 8'hA5, 1'b1, nb);
        send(8'hFF, "id_a5", 8'h5A);

        // Bit reversal permutation
        for (int i = 0; i < N; i++) tm[i] = 8'h01 << (N - 1 - i);
        do_cfg(tm, 8'h00, 1'b1, nb);
        expect_eq("rev_busy_cycles", nb, LAT);
        send(8'h01, "rev_01", 8'h80);
        send(8'h0F, "rev_0f", 8'hF0);

        // Singular: row1 equals row0
        tm    = ident();
        tm[1] = 8'h01;
        do_cfg(tm, 8'h00, 1'b1, nb);
        repeat (LAT) @(negedge clk);
        in_valid = 1'b1;
        din      = 8'h55;
        #1;
        expect_eq("sing_flag", 32'(singular), 1);
        expect_eq("sing_in_ready", 32'(in_ready), 0);
        expect_eq("sing_busy", 32'(busy), 0);
        expect_eq("sing_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        do_cfg(ident(), 8'h00, 1'b1, nb);
        expect_eq("resing_flag", 32'(singular), 0);
        expect_eq("resing_in_ready", 32'(in_ready), 1);

        // Random invertible T/t through forward stage + this block
        for (int a = 0; a < 30; a++) begin
            for (int i = 0; i < N; i++) tm[i] = N'($urandom);
            tv = N'($urandom);
            do_cfg(tm, tv, 1'b1, nb);
            if (!singular) break;
        end
        expect_eq("rand_invertible", 32'(singular), 0);
        for (int i = 0; i < 256; i++) xs[i] = N'($urandom);
        tx  = 0;
        rx  = 0;
        cyc = 0;
        while (rx < 256 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (tx < 256) && ($urandom_range(0, 4) != 0);
            din       = (tx < 256) ? fwd(tm, tv, xs[tx]) : '0;
            #1;
            if (out_valid && out_ready) begin
                expect_eq("stream", 32'(dout), 32'(xs[rx]));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        expect_eq("stream_count", rx, 256);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        expect_eq("stream_no_dup", 32'(out_valid), 0);

        // Reset in the middle of elimination
        do_cfg(ident(), 8'h00, 1'b0, nb);
        repeat (3) @(negedge clk);
        expect_eq("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_eq("mid_rst_cfg_ready", 32'(cfg_ready), 1);
        expect_eq("mid_rst_busy", 32'(busy), 0);
        expect_eq("mid_rst_out_valid", 32'(out_valid), 0);
        expect_eq("mid_rst_singular", 32'(singular), 0);
        do_cfg(ident(), 8'h0F, 1'b1, nb);
        send(8'h5A, "post_rst", 8'h55);

`ifdef INV_SELFCHECK_EN
        // Corrupt Tinv during the CHECK cycle
        do_cfg(ident(), 8'h00, 1'b0, nb);
        repeat (N) @(negedge clk);
        tm    = ident();
        tm[0] = 8'h03;
        force dut.tinv_q = tm;
        @(negedge clk);
        release dut.tinv_q;
        expect_eq("selfcheck_err", 32'(check_err), 1);
        expect_eq("selfcheck_singular", 32'(singular), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
